// File: rtl/gpr_file_sb_if.sv
// gpr_file_sb_if: bus bundle for the scoreboarded general-purpose register file.
//
// The master side is the pipeline: decode/issue drives the read addresses,
// rd_en and lock requests, and execute/writeback drives the X/Y write ports.
// The slave side is the register file, which returns registered read data,
// rd_vld, the combinational lock_ack and the busy scoreboard.
//
// Signals:
//   rd_adr_a/b/c, rd_en        read addresses and capture strobe
//   a, b, c, rd_vld            registered read data and validity
//   wr_adr_x/wr_enb_x/x        write port X (wins over Y on the same address)
//   wr_adr_y/wr_enb_y/y        write port Y
//   lock_adr, lock_enb         destination lock request
//   lock_ack                   lock accepted this cycle
//   busy                       per-register busy scoreboard
interface gpr_file_sb_if #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
);
    logic [AW-1:0]    rd_adr_a;
    logic [AW-1:0]    rd_adr_b;
    logic [AW-1:0]    rd_adr_c;
    logic             rd_en;
    logic [DW-1:0]    a;
    logic [DW-1:0]    b;
    logic [DW-1:0]    c;
    logic             rd_vld;
    logic [AW-1:0]    wr_adr_x;
    logic             wr_enb_x;
    logic [DW-1:0]    x;
    logic [AW-1:0]    wr_adr_y;
    logic             wr_enb_y;
    logic [DW-1:0]    y;
    logic [AW-1:0]    lock_adr;
    logic             lock_enb;
    logic             lock_ack;
    logic [DEPTH-1:0] busy;

    modport master (
        output rd_adr_a, rd_adr_b, rd_adr_c, rd_en,
        output wr_adr_x, wr_enb_x, x, wr_adr_y, wr_enb_y, y,
        output lock_adr, lock_enb,
        input  a, b, c, rd_vld, lock_ack, busy
    );

    modport slave (
        input  rd_adr_a, rd_adr_b, rd_adr_c, rd_en,
        input  wr_adr_x, wr_enb_x, x, wr_adr_y, wr_enb_y, y,
        input  lock_adr, lock_enb,
        output a, b, c, rd_vld, lock_ack, busy
    );
endinterface

// File: rtl/gpr_file_sb.sv
// gpr_file_sb: parametrised general-purpose register file with two write
// ports (X, Y), three registered read ports (A, B, C) and a per-register
// busy scoreboard driven by a lock/acknowledge handshake.
//
// Ports:
//   clock   rising-edge clock
//   reset   synchronous, active-high; clears registers, read outputs, busy
//   bus     gpr_file_sb_if slave modport (reads, writes, lock, scoreboard)
//
// Parameters:
//   DW      data width
//   DEPTH   number of registers (power of two, 2..64)
//   AW      address width, log2(DEPTH)
//   ZERO_R0 when 1, register 0 reads 0, ignores writes and is never busy
//
// Optional feature (macro GPR_BYPASS_EN): read capture forwards same-cycle
// X/Y write data, and a register written this cycle counts as not busy for
// rd_vld unless it is also lock-accepted in the same cycle.
module gpr_file_sb #(
    parameter int DW      = 32,
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int ZERO_R0 = 0
) (
    input  logic         clock,
    input  logic         reset,
    gpr_file_sb_if.slave bus
);

    logic [DW-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] wr_hit;
    logic [DEPTH-1:0] lock_set;
    logic [DEPTH-1:0] busy_rd;
    logic             wr_x_ok;
    logic             wr_y_ok;
    logic             lock_ack_c;
    logic [DW-1:0]    a_p0, b_p0, c_p0;
    logic             vld_p0;
    logic [DW-1:0]    a_p1, b_p1, c_p1;
    logic             vld_p1;

    function automatic logic is_zero_reg(input logic [AW-1:0] adr);
        return (ZERO_R0 != 0) && (adr == '0);
    endfunction

    // Writes aimed at a hardwired-zero register are dropped up front so they
    // neither store, forward nor touch the scoreboard.
    assign wr_x_ok = bus.wr_enb_x && !is_zero_reg(bus.wr_adr_x);
    assign wr_y_ok = bus.wr_enb_y && !is_zero_reg(bus.wr_adr_y);

    assign lock_ack_c = bus.lock_enb && !reset &&
                        (is_zero_reg(bus.lock_adr) || !busy_q[bus.lock_adr]);
    assign bus.lock_ack = lock_ack_c;

    // A dropped Y write still lands in wr_hit, so it clears busy like X does.
    always_comb begin
        wr_hit   = '0;
        lock_set = '0;
        for (int n = 0; n < DEPTH; n++) begin
            if (wr_x_ok && (bus.wr_adr_x == AW'(n))) wr_hit[n] = 1'b1;
            if (wr_y_ok && (bus.wr_adr_y == AW'(n))) wr_hit[n] = 1'b1;
            if (lock_ack_c && !is_zero_reg(bus.lock_adr) &&
                (bus.lock_adr == AW'(n))) lock_set[n] = 1'b1;
        end
    end

    // ---- stage p0: read selection (stored state, optionally forwarded) ----
`ifdef GPR_BYPASS_EN
    function automatic logic [DW-1:0] fwd(
        input logic [AW-1:0] adr,
        input logic [DW-1:0] stored,
        input logic          x_ok,
        input logic [AW-1:0] x_adr,
        input logic [DW-1:0] x_dat,
        input logic          y_ok,
        input logic [AW-1:0] y_adr,
        input logic [DW-1:0] y_dat
    );
        if (x_ok && (x_adr == adr)) return x_dat;
        if (y_ok && (y_adr == adr)) return y_dat;
        return stored;
    endfunction

    assign a_p0 = fwd(bus.rd_adr_a, regs[bus.rd_adr_a], wr_x_ok, bus.wr_adr_x,
                      bus.x, wr_y_ok, bus.wr_adr_y, bus.y);
    assign b_p0 = fwd(bus.rd_adr_b, regs[bus.rd_adr_b], wr_x_ok, bus.wr_adr_x,
                      bus.x, wr_y_ok, bus.wr_adr_y, bus.y);
    assign c_p0 = fwd(bus.rd_adr_c, regs[bus.rd_adr_c], wr_x_ok, bus.wr_adr_x,
                      bus.x, wr_y_ok, bus.wr_adr_y, bus.y);
    // Written this cycle -> not busy, unless the same register is also being
    // locked now (a lock can only be accepted on a non-busy register).
    assign busy_rd = (busy_q & ~wr_hit) | (wr_hit & lock_set);
`else
    assign a_p0 = regs[bus.rd_adr_a];
    assign b_p0 = regs[bus.rd_adr_b];
    assign c_p0 = regs[bus.rd_adr_c];
    assign busy_rd = busy_q;
`endif

    assign vld_p0 = !busy_rd[bus.rd_adr_a] && !busy_rd[bus.rd_adr_b] &&
                    !busy_rd[bus.rd_adr_c];

    // ---- stage p1: registered read outputs ----
    always_ff @(posedge clock) begin
        if (reset) begin
            a_p1   <= '0;
            b_p1   <= '0;
            c_p1   <= '0;
            vld_p1 <= 1'b0;
        end else if (bus.rd_en) begin
            a_p1   <= a_p0;
            b_p1   <= b_p0;
            c_p1   <= c_p0;
            vld_p1 <= vld_p0;
        end
    end

    assign bus.a      = a_p1;
    assign bus.b      = b_p1;
    assign bus.c      = c_p1;
    assign bus.rd_vld = vld_p1;

    // Register array: X has priority over Y on a shared address.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int n = 0; n < DEPTH; n++) regs[n] <= '0;
        end else begin
            for (int n = 0; n < DEPTH; n++) begin
                if (wr_x_ok && (bus.wr_adr_x == AW'(n))) begin
                    regs[n] <= bus.x;
                end else if (wr_y_ok && (bus.wr_adr_y == AW'(n))) begin
                    regs[n] <= bus.y;
                end
            end
        end
    end

    // Scoreboard: a same-cycle lock beats a clearing write.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~wr_hit) | lock_set;
        end
    end

    assign bus.busy = busy_q;

endmodule

// File: doc/gpr_file_sb.md
Name: gpr_file_sb

Overview:
- Parametrised successor to the fixed 16x32 general-purpose register file.
- Configurable data width and register count; two write ports (X, Y) and three registered read ports (A, B, C).
- Adds a per-register busy scoreboard with a lock/acknowledge handshake, read enable/valid, and an optional hardwired-zero register.
- Sits between the decode/issue stage (reads, locks) and the execute/writeback stages (X/Y writes).

Parameters:
- DW, 32, data width of every register and port.
- DEPTH, 16, number of registers; power of two, 2..64.
- AW, 4, address width; must equal log2(DEPTH).
- ZERO_R0, 0, when 1 register 0 always reads 0, ignores writes and is never busy.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- rd_adr_a  in  AW  read address A
- rd_adr_b  in  AW  read address B
- rd_adr_c  in  AW  read address C
- rd_en  in  1  capture A/B/C this cycle
- a  out  DW  registered read data A
- b  out  DW  registered read data B
- c  out  DW  registered read data C
- rd_vld  out  1  registered; A/B/C captured with no busy source
- wr_adr_x  in  AW  write address X
- wr_enb_x  in  1  write enable X
- x  in  DW  write data X
- wr_adr_y  in  AW  write address Y
- wr_enb_y  in  1  write enable Y
- y  in  DW  write data Y
- lock_adr  in  AW  destination register to mark busy
- lock_enb  in  1  lock request
- lock_ack  out  1  combinational; lock accepted this cycle
- busy  out  DEPTH  registered scoreboard, bit n = register n busy

Behaviour:
- Reset (sync):
  - All registers = 0; a = b = c = 0; rd_vld = 0; busy = 0.
  - lock_ack = 0 while reset is high.
- Write:
  - Registers update on the clock edge.
  - X and Y to the same address in the same cycle: X wins, Y is dropped.
  - A write to a non-busy register is legal and clears nothing.
  - ZERO_R0 = 1: writes to address 0 are discarded.
- Read:
  - When rd_en = 1, a/b/c load the register contents on the edge, giving one-cycle latency.
  - When rd_en = 0, a/b/c and rd_vld hold their values.
  - Without the bypass feature, a write in cycle N is visible on a/b/c only for reads issued in cycle N+1 or later.
- rd_vld:
  - Loads on rd_en = 1 only.
  - Next value = 1 iff busy[rd_adr_a], busy[rd_adr_b] and busy[rd_adr_c] are all 0, using the pre-edge busy state.
  - Data is still captured when rd_vld = 0; the consumer must discard it and reissue.
- Lock handshake:
  - lock_ack = lock_enb & ~busy[lock_adr] & ~reset.
  - With ZERO_R0 = 1, lock_ack = lock_enb & ~reset for address 0, and busy[0] stays 0.
  - Accepted lock sets busy[lock_adr] on the edge.
  - Lock on an already-busy register gives lock_ack = 0 with no state change; the issuer stalls and retries.
- Busy clear:
  - A write X or Y to address n clears busy[n] on the edge.
  - A dropped Y write (same address as X) still clears, since it is the same register.
- Simultaneous events on the same register n in one cycle:
  - Accepted lock plus write: lock has priority, so busy[n] = 1 after the edge and the register takes the write data.
  - Lock plus read of n: rd_vld uses pre-edge busy, so the read is valid if n was not busy.
- Reset mid-operation: all pending busy bits and any in-flight captures are discarded; the state is as at reset.

Optional Feature:
- Macro: GPR_BYPASS_EN.
- Defined:
  - Read capture forwards same-cycle write data.
  - Per port: if wr_enb_x and wr_adr_x == rd_adr, take x; else if wr_enb_y and wr_adr_y == rd_adr, take y; else take the stored value.
  - A register written this cycle counts as not busy for rd_vld, unless it is also accepted-locked this cycle.
  - With ZERO_R0 = 1, address 0 is never forwarded.
- Undefined: no forwarding; read data and rd_vld use stored state only, as described in Behaviour.

Test Plan:
- Reset, then rd_en with A/B/C = 3/5/0 -> next cycle a = b = c = 0, rd_vld = 1, busy = 0.
- Write X = 0xDEADBEEF to reg 3 and Y = 0x12345678 to reg 3 in the same cycle; read A = 3 next cycle -> a = 0xDEADBEEF.
- Lock reg 5 (lock_ack = 1), then lock reg 5 again -> lock_ack = 0, busy[5] = 1; read B = 5 -> rd_vld = 0; write Y = 0x55 to reg 5, then read -> b = 0x55, rd_vld = 1, busy[5] = 0.
- Same cycle: lock reg 7 plus X write to reg 7 = 0xA5 -> busy[7] = 1 after the edge, and reg 7 holds 0xA5 (check via read after a later clearing write of the same value).
- Bypass: write X = 0xCAFE to reg 9 while rd_en with C = 9 -> with GPR_BYPASS_EN, c = 0xCAFE the next cycle; without it, c = the old value (0 after reset).
- ZERO_R0 = 1: write 0xFFFF to reg 0, lock reg 0 -> lock_ack = 1, busy[0] = 0, and reading reg 0 gives a = 0 with rd_vld = 1.
